avl_wait_bridge: RTL and testbench



---
 rtl/avl_wait_bridge.sv | 161 ++++++++++++++++
 tb/tb_avl_wait_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_wait_bridge.sv
// ----------------------------------------------------------------------------
// avl_wait_bridge
//
// Avalon-MM pass-through bridge placed between the CPU bus master and the
// slave memory. Each CPU transfer is captured into registers and then held
// off with waitrequest for a programmable number of cycles. Optionally, a
// pseudo-random 0..3 extra cycles are added per transfer. After that delay
// the transfer is issued downstream. This exercises the CPU's waitrequest
// handling under varied latency.
//
// Handshake: the CPU keeps s_read/s_write and its address and data stable
// while s_waitrequest=1. The transfer completes on the first rising edge
// where s_waitrequest=0. The downstream side follows the same rule: m_* stay
// stable while m_waitrequest=1, and the memory accepts on the edge where
// m_waitrequest=0.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   s_address/byteenable/writedata/read/write   request from the CPU
//   s_readdata, s_waitrequest                   response to the CPU
//   m_address/byteenable/writedata/read/write   request to the memory
//   m_readdata, m_waitrequest                   response from the memory
//   txn_count     completed transfers (saturating)
//   stall_count   cycles with s_waitrequest=1 (saturating)
//   protocol_err  sticky: s_read and s_write seen high together
// ----------------------------------------------------------------------------
module avl_wait_bridge #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter bit          RAND_EN     = 1'b0,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_address,
    input  logic [3:0]  s_byteenable,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic [31:0] m_address,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic [31:0] txn_count,
    output logic [31:0] stall_count,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0]  LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [8:0]  WAIT_BASE = 9'(WAIT_CYCLES);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    state_t      state;
    logic [8:0]  cnt;
    logic [7:0]  lfsr;
    logic        is_read;
    logic        req;
    logic        lfsr_fb;
    logic [8:0]  cnt_load;

    assign req           = s_read | s_write;
    assign s_waitrequest = req && (state != RESP);

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign cnt_load = WAIT_BASE + (RAND_EN ? {7'd0, lfsr[1:0]} : 9'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lfsr         <= LFSR_INIT;
            is_read      <= 1'b0;
            s_readdata   <= '0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            txn_count    <= '0;
            stall_count  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (s_waitrequest && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        m_address    <= s_address;
                        m_byteenable <= s_byteenable;
                        m_writedata  <= s_writedata;
                        // A read wins when both strobes are high.
                        is_read      <= s_read;
                        if (s_read && s_write) begin
                            protocol_err <= 1'b1;
                        end
                        // The LFSR advances only when a transfer is captured.
                        lfsr <= {lfsr[6:0], lfsr_fb};
                        if (cnt_load != 9'd0) begin
                            cnt   <= cnt_load;
                            state <= DELAY;
                        end else begin
                            m_read  <= s_read;
                            m_write <= ~s_read;
                            state   <= ISSUE;
                        end
                    end
                end

                DELAY: begin
                    // Exactly cnt cycles are spent here before the issue.
                    if (cnt == 9'd1) begin
                        cnt     <= '0;
                        m_read  <= is_read;
                        m_write <= ~is_read;
                        state   <= ISSUE;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end

                ISSUE: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (is_read) begin
                            s_readdata <= m_readdata;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    // The CPU completes on this edge. The transfer is counted
                    // even if the CPU already dropped its request.
                    if (txn_count != CNT_MAX) begin
                        txn_count <= txn_count + 32'd1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avl_wait_bridge.sv
// ----------------------------------------------------------------------------
// tb_avl_wait_bridge
//
// Directed bench for avl_wait_bridge. It uses three instances that share the
// CPU-side stimulus and the memory model:
//   u_a : WAIT_CYCLES=2, RAND_EN=0  (main instance, tests 1-5)
//   u_b : WAIT_CYCLES=0, RAND_EN=0  (zero-delay read after reset, test 5)
//   u_c : WAIT_CYCLES=2, RAND_EN=1, SEED=8'hA5 (random stalls, test 6)
//
// Timing: inputs are driven 1ns after a rising edge, and outputs are sampled
// on the falling edge.
//
// Memory model: m_waitrequest is raised for the first mem_ws cycles of each
// strobe from u_a. mem_hold forces it high.
// ----------------------------------------------------------------------------
module tb_avl_wait_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_address = '0;
    logic [3:0]  s_byteenable = '0;
    logic [31:0] s_writedata = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest;

    logic [31:0] s_readdata    [3];
    logic        s_waitrequest [3];
    logic [31:0] m_address     [3];
    logic [3:0]  m_byteenable  [3];
    logic [31:0] m_writedata   [3];
    logic        m_read        [3];
    logic        m_write       [3];
    logic [31:0] txn_count     [3];
    logic [31:0] stall_count   [3];
    logic        protocol_err  [3];

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    avl_wait_bridge #(.WAIT_CYCLES(2), .RAND_EN(1'b0), .SEED(8'hA5)) u_a (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write),
        .s_readdata(s_readdata[0]), .s_waitrequest(s_waitrequest[0]),
        .m_address(m_address[0]), .m_byteenable(m_byteenable[0]), .m_writedata(m_writedata[0]),
        .m_read(m_read[0]), .m_write(m_write[0]),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .txn_count(txn_count[0]), .stall_count(stall_count[0]), .protocol_err(protocol_err[0])
    );

    avl_wait_bridge #(.WAIT_CYCLES(0), .RAND_EN(1'b0), .SEED(8'hA5)) u_b (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write),
        .s_readdata(s_readdata[1]), .s_waitrequest(s_waitrequest[1]),
        .m_address(m_address[1]), .m_byteenable(m_byteenable[1]), .m_writedata(m_writedata[1]),
        .m_read(m_read[1]), .m_write(m_write[1]),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .txn_count(txn_count[1]), .stall_count(stall_count[1]), .protocol_err(protocol_err[1])
    );

    avl_wait_bridge #(.WAIT_CYCLES(2), .RAND_EN(1'b1), .SEED(8'hA5)) u_c (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write),
        .s_readdata(s_readdata[2]), .s_waitrequest(s_waitrequest[2]),
        .m_address(m_address[2]), .m_byteenable(m_byteenable[2]), .m_writedata(m_writedata[2]),
        .m_read(m_read[2]), .m_write(m_write[2]),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .txn_count(txn_count[2]), .stall_count(stall_count[2]), .protocol_err(protocol_err[2])
    );

    // ---------------- memory model ----------------
    int   mem_ws   = 0;
    logic mem_hold = 1'b0;
    int   issue_run = 0;

    assign m_waitrequest = mem_hold || ((m_read[0] || m_write[0]) && (issue_run < mem_ws));

    always @(posedge clk) begin
        issue_run <= ((m_read[0] || m_write[0]) && m_waitrequest) ? issue_run + 1 : 0;
    end

    // Monitor of u_a's downstream strobes and of write-field stability.
    int          mw_cycles = 0;
    int          mr_cycles = 0;
    int          mw_unstable = 0;
    int          wr_accepts = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [3:0]  exp_be = '0;

    always @(negedge clk) begin
        if (m_write[0]) begin
            mw_cycles++;
            if (m_address[0] !== exp_addr || m_writedata[0] !== exp_data ||
                m_byteenable[0] !== exp_be) begin
                mw_unstable++;
            end
            if (!m_waitrequest) wr_accepts++;
        end
        if (m_read[0]) mr_cycles++;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts falling-edge samples with s_waitrequest=1 on instance idx until
    // the RESP cycle. Returns at the falling edge of the RESP cycle.
    task automatic wait_resp(input int idx, input int start, input string tag,
                             output int stalls, output logic [31:0] rd);
        logic done;
        done   = 1'b0;
        stalls = start;
        rd     = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_waitrequest[idx]) begin
                stalls++;
            end else begin
                rd   = s_readdata[idx];
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Golden LFSR: 8-bit Fibonacci, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int          stalls;
        logic [31:0] rd;
        int          mw0, mr0, un0, wa0;
        logic        seen;
        logic [7:0]  gl;
        int          sum;

        // ---- 1: reset ----
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_s_waitrequest", {31'd0, s_waitrequest[0]}, 32'd0);
        chk("t1_s_readdata", s_readdata[0], 32'd0);
        chk("t1_m_strobes", {30'd0, m_read[0], m_write[0]}, 32'd0);
        chk("t1_m_address", m_address[0], 32'd0);
        chk("t1_m_writedata", m_writedata[0], 32'd0);
        chk("t1_m_byteenable", {28'd0, m_byteenable[0]}, 32'd0);
        chk("t1_txn_count", txn_count[0], 32'd0);
        chk("t1_stall_count", stall_count[0], 32'd0);
        chk("t1_protocol_err", {31'd0, protocol_err[0]}, 32'd0);
        chk("t1_state", 32'(u_a.state), 32'd0);

        // ---- 2: read, 2 wait cycles, zero-wait memory ----
        step();
        mr0 = mr_cycles;
        m_readdata   = 32'hDEADBEEF;
        mem_ws       = 0;
        s_address    = 32'hBFC0_0000;
        s_byteenable = 4'hF;
        s_read       = 1'b1;
        wait_resp(0, 0, "t2", stalls, rd);
        chk("t2_stalls", 32'(stalls), 32'd4);
        chk("t2_readdata", rd, 32'hDEADBEEF);
        chk("t2_m_read_cycles", 32'(mr_cycles - mr0), 32'd1);
        step();
        s_read = 1'b0;
        chk("t2_txn_count", txn_count[0], 32'd1);
        chk("t2_stall_count", stall_count[0], 32'd4);

        // ---- 3: write, memory waitrequest 3 cycles, address changed in DELAY ----
        mw0 = mw_cycles;
        un0 = mw_unstable;
        wa0 = wr_accepts;
        exp_addr     = 32'h0000_1000;
        exp_data     = 32'h1234_5678;
        exp_be       = 4'b0011;
        mem_ws       = 3;
        m_readdata   = 32'h5555_AAAA;
        s_address    = 32'h0000_1000;
        s_writedata  = 32'h1234_5678;
        s_byteenable = 4'b0011;
        s_write      = 1'b1;
        @(negedge clk);
        chk("t3_first_wait", {31'd0, s_waitrequest[0]}, 32'd1);
        step();
        chk("t3_state_delay", 32'(u_a.state), 32'd1);
        s_address = 32'h0000_2000;
        wait_resp(0, 1, "t3", stalls, rd);
        chk("t3_stalls", 32'(stalls), 32'd7);
        chk("t3_m_write_cycles", 32'(mw_cycles - mw0), 32'd4);
        chk("t3_fields_stable", 32'(mw_unstable - un0), 32'd0);
        chk("t3_write_accepts", 32'(wr_accepts - wa0), 32'd1);
        chk("t3_m_address", m_address[0], 32'h0000_1000);
        chk("t3_readdata_hold", rd, 32'hDEADBEEF);
        step();
        s_write = 1'b0;
        mem_ws  = 0;
        chk("t3_txn_count", txn_count[0], 32'd2);
        chk("t3_stall_count", stall_count[0], 32'd11);

        // ---- 4: read and write together ----
        mr0 = mr_cycles;
        mw0 = mw_cycles;
        m_readdata   = 32'hCAFE_F00D;
        s_address    = 32'h0000_0040;
        s_writedata  = 32'h0BAD_0BAD;
        s_byteenable = 4'hF;
        s_read       = 1'b1;
        s_write      = 1'b1;
        wait_resp(0, 0, "t4", stalls, rd);
        chk("t4_stalls", 32'(stalls), 32'd4);
        chk("t4_readdata", rd, 32'hCAFE_F00D);
        chk("t4_m_read_cycles", 32'(mr_cycles - mr0), 32'd1);
        chk("t4_m_write_cycles", 32'(mw_cycles - mw0), 32'd0);
        chk("t4_protocol_err", {31'd0, protocol_err[0]}, 32'd1);
        step();
        s_read  = 1'b0;
        s_write = 1'b0;
        // A clean write follows. The error flag stays set and the read data holds.
        un0 = mw_unstable;
        exp_addr     = 32'h0000_0044;
        exp_data     = 32'hA5A5_5A5A;
        exp_be       = 4'b1100;
        m_readdata   = 32'h1111_2222;
        s_address    = 32'h0000_0044;
        s_writedata  = 32'hA5A5_5A5A;
        s_byteenable = 4'b1100;
        s_write      = 1'b1;
        wait_resp(0, 0, "t4b", stalls, rd);
        chk("t4b_stalls", 32'(stalls), 32'd4);
        chk("t4b_readdata_hold", rd, 32'hCAFE_F00D);
        chk("t4b_fields_stable", 32'(mw_unstable - un0), 32'd0);
        step();
        s_write = 1'b0;
        chk("t4b_protocol_err_sticky", {31'd0, protocol_err[0]}, 32'd1);
        chk("t4b_txn_count", txn_count[0], 32'd4);
        chk("t4b_stall_count", stall_count[0], 32'd19);

        // ---- 5: reset during ISSUE with the memory stalling ----
        mem_hold  = 1'b1;
        s_address = 32'h0000_0080;
        s_read    = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_read[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_reached_issue", {31'd0, seen}, 32'd1);
        step();
        rst      = 1'b1;
        s_read   = 1'b0;
        mem_hold = 1'b0;
        step();
        rst = 1'b0;
        chk("t5_m_read", {31'd0, m_read[0]}, 32'd0);
        chk("t5_txn_count", txn_count[0], 32'd0);
        chk("t5_stall_count", stall_count[0], 32'd0);
        chk("t5_protocol_err", {31'd0, protocol_err[0]}, 32'd0);
        chk("t5_state", 32'(u_a.state), 32'd0);
        // Zero-delay read on u_b.
        m_readdata = 32'h7777_0000;
        s_address  = 32'h0000_0084;
        s_read     = 1'b1;
        wait_resp(1, 0, "t5b", stalls, rd);
        chk("t5b_stalls", 32'(stalls), 32'd2);
        chk("t5b_readdata", rd, 32'h7777_0000);
        step();
        s_read = 1'b0;
        chk("t5b_txn_count", txn_count[1], 32'd1);
        chk("t5b_stall_count", stall_count[1], 32'd2);

        // ---- 6: random stalls, 16 back-to-back reads on u_c ----
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        gl  = 8'hA5;
        sum = 0;
        m_readdata = 32'h0000_0000;
        s_address  = 32'h0000_0100;
        s_read     = 1'b1;
        for (int k = 0; k < 16; k++) begin
            m_readdata = 32'h6000_0000 + 32'(k);
            wait_resp(2, 0, $sformatf("t6_%0d", k), stalls, rd);
            chk($sformatf("t6_stall_%0d", k), 32'(stalls), 32'd4 + {30'd0, gl[1:0]});
            sum = sum + 4 + int'(gl[1:0]);
            gl  = lfsr_next(gl);
        end
        step();
        s_read = 1'b0;
        chk("t6_txn_count", txn_count[2], 32'd16);
        chk("t6_stall_count", stall_count[2], 32'(sum));

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
